voice_allocator: RTL and testbench

Maps incoming MIDI note-on/note-off events to synthesizer voice slots. It produces keystate updates (voice index plus on/off) for the ADSR envelope block and the per-voice oscillator pipeline. It keeps a per-voice table of active flag, note number and age. Note-on prefers a retrigger of the same note, then a free voice, then steals the oldest voice. Sits between the SPI/MIDI command decoder and the ADSR keystate update port.

---
 rtl/synth_pkg.sv | 33 +++
 rtl/voice_table.sv | 70 +++++++
 rtl/voice_allocator.sv | 188 ++++++++++++++++++
 tb/tb_voice_allocator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : synth_pkg
// Purpose  : Shared types for the voice allocator and the ADSR keystate path.
// Revision : 1.0
// ============================================================================
package synth_pkg;

   localparam int NOTE_W      = 7;
   localparam int MAX_AGE_W   = 16;
   localparam int UPD_VOICE_W = 8;

   typedef struct packed {
      logic                 active;
      logic [NOTE_W-1:0]    note;
      logic [MAX_AGE_W-1:0] age;
   } voice_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_DECIDE = 2'd2,
      ST_EMIT   = 2'd3
   } alloc_state_e;

   typedef struct packed {
      logic [UPD_VOICE_W-1:0] voice;
      logic                   status;
      logic [NOTE_W-1:0]      note;
   } key_update_t;

endpackage
`default_nettype wire

// File: rtl/voice_table.sv
`default_nettype none
// ============================================================================
// Module   : voice_table
// Purpose  : Per-voice active/note/age register file, one scan read port,
//            one write port; age logic present only with VOICE_STEAL_EN.
// Revision : 1.0
// ============================================================================
module voice_table
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int IDX_W      = 3,
   parameter int AGE_W      = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output voice_entry_t      o_rd_entry,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic              i_wr_active,
   input  logic [NOTE_W-1:0] i_wr_note,
   input  logic              i_age_en
);

   logic              r_active [NUM_VOICES];
   logic [NOTE_W-1:0] r_note   [NUM_VOICES];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_active[v] <= 1'b0;
            r_note[v]   <= '0;
         end
      end else if (i_wr_en) begin
         r_active[i_wr_idx] <= i_wr_active;
         r_note[i_wr_idx]   <= i_wr_note;
      end
   end

   assign o_rd_entry.active = r_active[i_rd_idx];
   assign o_rd_entry.note   = r_note[i_rd_idx];

`ifdef VOICE_STEAL_EN
   logic [AGE_W-1:0] r_age [NUM_VOICES];

   // On every allocation the chosen voice restarts at 0 and all other
   // sounding voices grow one step older, saturating at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int v = 0; v < NUM_VOICES; v++) r_age[v] <= '0;
      end else if (i_wr_en && i_age_en) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (IDX_W'(v) == i_wr_idx)
               r_age[v] <= '0;
            else if (r_active[v] && (r_age[v] != '1))
               r_age[v] <= r_age[v] + AGE_W'(1);
         end
      end
   end

   assign o_rd_entry.age = MAX_AGE_W'(r_age[i_rd_idx]);
`else
   logic [AGE_W-1:0] unused_age_en;
   assign unused_age_en  = AGE_W'(i_age_en);
   assign o_rd_entry.age = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Purpose  : Maps MIDI note-on/off events onto voice slots and emits keystate
//            updates. Optional macro VOICE_STEAL_EN enables oldest-voice steal.
// Revision : 1.0
// ============================================================================
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int VOICE_W    = 8,
   parameter int AGE_W      = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_evt_valid,
   input  logic               i_evt_note_on,
   input  logic [NOTE_W-1:0]  i_evt_note,
   output logic               o_evt_ready,
   output logic               o_upd_valid,
   output logic               o_upd_note_status,
   output logic [VOICE_W-1:0] o_upd_voice,
   output logic [NOTE_W-1:0]  o_upd_note,
   input  logic               i_upd_ready,
`ifndef VOICE_STEAL_EN
   output logic               o_drop,
`endif
   output logic [VOICE_W:0]   o_active_count
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
   localparam logic [1:0] S_SCAN   = 2'(ST_SCAN);
   localparam logic [1:0] S_DECIDE = 2'(ST_DECIDE);
   localparam logic [1:0] S_EMIT   = 2'(ST_EMIT);

   localparam logic [VOICE_W:0] c_count_one = 1;

   logic [1:0]         r_state;
   logic [IDX_W-1:0]   r_scan_idx;
   logic               r_note_on;
   logic [NOTE_W-1:0]  r_note;
   logic               r_match_found;
   logic               r_free_found;
   logic [IDX_W-1:0]   r_match_idx;
   logic [IDX_W-1:0]   r_free_idx;
   logic [VOICE_W-1:0] r_upd_voice;
   logic               r_upd_status;
   logic [NOTE_W-1:0]  r_upd_note;
   logic [VOICE_W:0]   r_active_count;

   voice_entry_t       w_rd_entry;
   logic               w_hit;
   logic               w_do_write;
   logic               w_wr_en;
   logic [IDX_W-1:0]   w_sel_idx;

`ifdef VOICE_STEAL_EN
   logic [IDX_W-1:0]     r_oldest_idx;
   logic [MAX_AGE_W-1:0] r_oldest_age;
`else
   logic [AGE_W-1:0]     w_unused_age;
   assign w_unused_age = AGE_W'(^w_rd_entry.age);
`endif

   // Note-off only ever acts on a matching voice; note-on falls back to a
   // free voice and, when stealing, to the oldest one.
   always_comb begin
      w_hit     = r_match_found || r_free_found;
      w_sel_idx = r_match_found ? r_match_idx : r_free_idx;
`ifdef VOICE_STEAL_EN
      if (!w_hit) w_sel_idx = r_oldest_idx;
      w_do_write = r_note_on || r_match_found;
`else
      w_do_write = r_note_on ? w_hit : r_match_found;
`endif
   end

   assign w_wr_en = (r_state == S_DECIDE) && w_do_write;

   voice_table #(
      .NUM_VOICES (NUM_VOICES),
      .IDX_W      (IDX_W),
      .AGE_W      (AGE_W)
   ) u_table (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_rd_idx    (r_scan_idx),
      .o_rd_entry  (w_rd_entry),
      .i_wr_en     (w_wr_en),
      .i_wr_idx    (w_sel_idx),
      .i_wr_active (r_note_on),
      .i_wr_note   (r_note),
      .i_age_en    (r_note_on)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= S_IDLE;
         r_scan_idx     <= '0;
         r_note_on      <= 1'b0;
         r_note         <= '0;
         r_match_found  <= 1'b0;
         r_free_found   <= 1'b0;
         r_match_idx    <= '0;
         r_free_idx     <= '0;
         r_upd_voice    <= '0;
         r_upd_status   <= 1'b0;
         r_upd_note     <= '0;
         r_active_count <= '0;
`ifdef VOICE_STEAL_EN
         r_oldest_idx   <= '0;
         r_oldest_age   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_evt_valid) begin
                  r_note_on     <= i_evt_note_on;
                  r_note        <= i_evt_note;
                  r_scan_idx    <= '0;
                  r_match_found <= 1'b0;
                  r_free_found  <= 1'b0;
                  r_match_idx   <= '0;
                  r_free_idx    <= '0;
`ifdef VOICE_STEAL_EN
                  r_oldest_idx  <= '0;
                  r_oldest_age  <= '0;
`endif
                  r_state       <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_rd_entry.active && (w_rd_entry.note == r_note) && !r_match_found) begin
                  r_match_found <= 1'b1;
                  r_match_idx   <= r_scan_idx;
               end
               if (!w_rd_entry.active && !r_free_found) begin
                  r_free_found <= 1'b1;
                  r_free_idx   <= r_scan_idx;
               end
`ifdef VOICE_STEAL_EN
               if (w_rd_entry.age > r_oldest_age) begin
                  r_oldest_age <= w_rd_entry.age;
                  r_oldest_idx <= r_scan_idx;
               end
`endif
               if (r_scan_idx == IDX_W'(NUM_VOICES - 1))
                  r_state <= S_DECIDE;
               else
                  r_scan_idx <= r_scan_idx + IDX_W'(1);
            end
            S_DECIDE: begin
               if (w_do_write) begin
                  r_upd_voice  <= VOICE_W'(w_sel_idx);
                  r_upd_status <= r_note_on;
                  r_upd_note   <= r_note;
                  r_state      <= S_EMIT;
                  if (r_note_on && !r_match_found && r_free_found)
                     r_active_count <= r_active_count + c_count_one;
                  else if (!r_note_on)
                     r_active_count <= r_active_count - c_count_one;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_EMIT: begin
               if (i_upd_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_evt_ready       = (r_state == S_IDLE);
   assign o_upd_valid       = (r_state == S_EMIT);
   assign o_upd_note_status = r_upd_status;
   assign o_upd_voice       = r_upd_voice;
   assign o_upd_note        = r_upd_note;
   assign o_active_count    = r_active_count;
`ifndef VOICE_STEAL_EN
   assign o_drop = (r_state == S_DECIDE) && r_note_on && !w_hit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Purpose  : Directed self-checking bench for voice_allocator (8 voices).
// Revision : 1.0
// ============================================================================
module tb_voice_allocator;

   localparam int N = 8;

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_evt_valid = 1'b0;
   logic       i_evt_note_on = 1'b0;
   logic [6:0] i_evt_note = '0;
   logic       o_evt_ready;
   logic       o_upd_valid;
   logic       o_upd_note_status;
   logic [7:0] o_upd_voice;
   logic [6:0] o_upd_note;
   logic       i_upd_ready = 1'b0;
   logic [8:0] o_active_count;
`ifndef VOICE_STEAL_EN
   logic       o_drop;
`endif

   always #5 i_clk = ~i_clk;

   voice_allocator #(.NUM_VOICES(N), .VOICE_W(8), .AGE_W(8)) dut (
      .i_clk             (i_clk),
      .i_reset           (i_reset),
      .i_evt_valid       (i_evt_valid),
      .i_evt_note_on     (i_evt_note_on),
      .i_evt_note        (i_evt_note),
      .o_evt_ready       (o_evt_ready),
      .o_upd_valid       (o_upd_valid),
      .o_upd_note_status (o_upd_note_status),
      .o_upd_voice       (o_upd_voice),
      .o_upd_note        (o_upd_note),
      .i_upd_ready       (i_upd_ready),
`ifndef VOICE_STEAL_EN
      .o_drop            (o_drop),
`endif
      .o_active_count    (o_active_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: the voice table as plain arrays plus expected updates.
   typedef struct { int voice; int status; int note; } upd_t;
   upd_t exp_q[$];
   bit   m_act  [N];
   int   m_note [N];
   int   m_age  [N];
   int   exp_drops  = 0;
   int   seen_drops = 0;
   bit   mon_en     = 1'b0;

   function automatic int model_count();
      int c = 0;
      for (int v = 0; v < N; v++) c += m_act[v];
      return c;
   endfunction

   function automatic void model_clear();
      for (int v = 0; v < N; v++) begin
         m_act[v] = 1'b0; m_note[v] = 0; m_age[v] = 0;
      end
      exp_q.delete();
   endfunction

   function automatic int model_event(input bit on, input int note);
      int m = -1, f = -1, o = 0, sel;
      for (int v = 0; v < N; v++) begin
         if (m_act[v] && m_note[v] == note && m < 0) m = v;
         if (!m_act[v] && f < 0) f = v;
         if (m_age[v] > m_age[o]) o = v;
      end
      if (!on) begin
         if (m >= 0) begin
            m_act[m] = 1'b0;
            exp_q.push_back('{m, 0, note});
         end
         return m;
      end
      sel = (m >= 0) ? m : (f >= 0) ? f : -1;
`ifdef VOICE_STEAL_EN
      if (sel < 0) sel = o;
`endif
      if (sel < 0) begin
         exp_drops++;
         return -1;
      end
      for (int v = 0; v < N; v++)
         if (m_act[v] && v != sel) m_age[v] = (m_age[v] < 255) ? m_age[v] + 1 : 255;
      m_act[sel] = 1'b1; m_note[sel] = note; m_age[sel] = 0;
      exp_q.push_back('{sel, 1, note});
      return sel;
   endfunction

   always @(negedge i_clk) begin
      if (mon_en) begin
         if (o_upd_valid) begin
            if (exp_q.size() == 0) chk("unexpected_upd_valid", 1, 0);
            else begin
               chk("upd_voice",  int'(o_upd_voice),       exp_q[0].voice);
               chk("upd_status", int'(o_upd_note_status), exp_q[0].status);
               chk("upd_note",   int'(o_upd_note),        exp_q[0].note);
            end
         end
         if (o_evt_ready || o_upd_valid)
            chk("active_count", int'(o_active_count), model_count());
`ifndef VOICE_STEAL_EN
         if (o_drop) seen_drops++;
`endif
      end
   end

   task automatic do_reset();
      mon_en = 1'b0;
      i_reset = 1'b1; i_evt_valid = 1'b0; i_upd_ready = 1'b0;
      @(posedge i_clk);
      #1 i_reset = 1'b0;
      model_clear();
      @(negedge i_clk);
      chk("rst_evt_ready",  int'(o_evt_ready), 1);
      chk("rst_upd_valid",  int'(o_upd_valid), 0);
      chk("rst_status",     int'(o_upd_note_status), 0);
      chk("rst_voice",      int'(o_upd_voice), 0);
      chk("rst_note",       int'(o_upd_note), 0);
      chk("rst_count",      int'(o_active_count), 0);
      mon_en = 1'b1;
   endtask

   task automatic wait_ready(input string tag);
      int cyc = 0;
      while (!o_evt_ready && cyc < 64) begin @(negedge i_clk); cyc++; end
      chk({tag, "_ready"}, int'(o_evt_ready), 1);
   endtask

   // lit_voice is the hand-computed target voice (-1 = no update expected).
   task automatic send(input bit on, input int note, input int stall,
                       input int lit_voice, input string tag);
      int cyc, sel;
      wait_ready(tag);
      i_evt_valid = 1'b1; i_evt_note_on = on; i_evt_note = 7'(note);
      @(posedge i_clk);
      sel = model_event(on, note);
      chk({tag, "_model"}, sel, lit_voice);
      #1 i_evt_valid = 1'b0;
      cyc = 0;
      do begin @(negedge i_clk); cyc++; end
      while (!o_upd_valid && !o_evt_ready && cyc < 64);
      chk({tag, "_latency"}, cyc, N + 2);
      chk({tag, "_valid"}, int'(o_upd_valid), (lit_voice >= 0) ? 1 : 0);
      if (o_upd_valid) begin
         chk({tag, "_voice_lit"}, int'(o_upd_voice), lit_voice);
         for (int s = 0; s < stall; s++) begin
            @(negedge i_clk);
            chk({tag, "_hold"}, int'(o_upd_valid), 1);
         end
         i_upd_ready = 1'b1;
         @(posedge i_clk);
         #1 i_upd_ready = 1'b0;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         @(negedge i_clk);
         chk({tag, "_done_valid"}, int'(o_upd_valid), 0);
         chk({tag, "_done_ready"}, int'(o_evt_ready), 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      do_reset();

      send(1'b1, 60, 5, 0, "on60");
      chk("count_after_on60", int'(o_active_count), 1);

      send(1'b1, 62, 0, 1, "on62");
      send(1'b1, 64, 0, 2, "on64");
      send(1'b0, 62, 0, 1, "off62");
      chk("count_after_off62", int'(o_active_count), 2);
      send(1'b1, 67, 1, 1, "on67");

      send(1'b0, 70, 0, -1, "off70");
      send(1'b1, 60, 2, 0, "retrig60");
      chk("count_after_retrig", int'(o_active_count), 3);

      do_reset();
      for (int v = 0; v < N; v++) send(1'b1, 40 + v, 0, v, "fill");
      chk("count_full", int'(o_active_count), 8);
`ifdef VOICE_STEAL_EN
      send(1'b1, 50, 0, 0, "steal50");
      send(1'b1, 51, 0, 1, "steal51");
      chk("count_after_steal", int'(o_active_count), 8);
`else
      send(1'b1, 50, 0, -1, "drop50");
      send(1'b0, 45, 0, 5, "off45");
      send(1'b1, 50, 0, 5, "on50");
      chk("drop_pulses", seen_drops, exp_drops);
      chk("drop_pulses_lit", seen_drops, 1);
`endif

      // Reset in the middle of a scan discards the event.
      mon_en = 1'b0;
      wait_ready("scanrst");
      i_evt_valid = 1'b1; i_evt_note_on = 1'b1; i_evt_note = 7'd33;
      @(posedge i_clk);
      #1 i_evt_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("scan_busy", int'(o_evt_ready), 0);
      i_reset = 1'b1;
      @(posedge i_clk);
      #1 i_reset = 1'b0;
      model_clear();
      @(negedge i_clk);
      chk("scanrst_valid", int'(o_upd_valid), 0);
      chk("scanrst_count", int'(o_active_count), 0);
      chk("scanrst_ready", int'(o_evt_ready), 1);

      // Reset while an update waits for ready discards the update.
      i_evt_valid = 1'b1; i_evt_note_on = 1'b1; i_evt_note = 7'd33;
      @(posedge i_clk);
      #1 i_evt_valid = 1'b0;
      cyc = 0;
      do begin @(negedge i_clk); cyc++; end while (!o_upd_valid && cyc < 64);
      chk("emit_reached", int'(o_upd_valid), 1);
      chk("emit_count", int'(o_active_count), 1);
      chk("emit_voice", int'(o_upd_voice), 0);
      i_reset = 1'b1;
      @(posedge i_clk);
      #1 i_reset = 1'b0;
      @(negedge i_clk);
      chk("emitrst_valid", int'(o_upd_valid), 0);
      chk("emitrst_count", int'(o_active_count), 0);
      chk("emitrst_ready", int'(o_evt_ready), 1);

      // Table really cleared: the next note-on lands on voice 0 again.
      mon_en = 1'b1;
      send(1'b1, 33, 0, 0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
